spi_master_sequencer: RTL and testbench

Master-side SPI frame sequencer that generates serial clock, chip select and single-cycle serial-clock edge strobes for one fixed-length transaction per start request. Sits directly upstream of the master control FSM: its `cs` drives that FSM's chip-select input, and its `sclk_posedge` replaces the input-conditioned serial clock edge (`clkedge`). It also drives `sclk` and `cs` onto the SPI bus toward the slave.

---
 rtl/spi_master_sequencer.sv | 172 +++++++++++++++++
 tb/tb_spi_master_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_sequencer.sv
// spi_master_sequencer
// Master-side SPI frame sequencer. On each accepted start it drops cs, waits
// CS_SETUP cycles, issues FRAME_BITS serial clock periods (CPOL=0, DIV clk
// cycles per half-period), holds cs low for CS_HOLD cycles and then releases
// cs with a one-cycle done pulse. sclk_posedge / sclk_negedge are single-cycle
// strobes aligned with the first cycle of each sclk level, for use by the
// downstream master control FSM instead of a sampled serial clock edge.
//
// Optional feature macro: SPI_SEQ_ABORT_EN
//   defined   -> abort terminates a transaction (one-cycle aborted pulse)
//   undefined -> abort is ignored and aborted stays 0
module spi_master_sequencer #(
    parameter int DIV        = 4,
    parameter int FRAME_BITS = 16,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              abort,
    output logic                              busy,
    output logic                              done,
    output logic                              aborted,
    output logic                              cs,
    output logic                              sclk,
    output logic                              sclk_posedge,
    output logic                              sclk_negedge,
    output logic [$clog2(FRAME_BITS+1)-1:0]   bit_count
);

    localparam int CW = $clog2(FRAME_BITS + 1);

    // Terminal values of the 8-bit phase timer for each timed phase.
    localparam logic [7:0]    SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0]    HALF_LAST  = 8'(DIV - 1);
    localparam logic [7:0]    HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [CW-1:0] LAST_BIT   = CW'(FRAME_BITS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t     state;
    logic [7:0] timer;
    logic       abort_hit;

`ifdef SPI_SEQ_ABORT_EN
    // Abort only matters while a transaction is in flight.
    assign abort_hit = abort & (state != IDLE);
`else
    // Abort disabled: the port is kept for a stable interface but has no effect.
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_hit    = 1'b0;
`endif

    // Frame sequencing FSM with all outputs registered; abort overrides every
    // non-idle transition, including the final HOLD cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            cs           <= 1'b1;
            sclk         <= 1'b0;
            sclk_posedge <= 1'b0;
            sclk_negedge <= 1'b0;
            bit_count    <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            done         <= 1'b0;
            aborted      <= 1'b0;
            sclk_posedge <= 1'b0;
            sclk_negedge <= 1'b0;

            if (abort_hit) begin
                // Immediate termination: no trailing negedge strobe, no done.
                state   <= IDLE;
                timer   <= 8'd0;
                busy    <= 1'b0;
                cs      <= 1'b1;
                sclk    <= 1'b0;
                aborted <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        timer <= 8'd0;
                        if (start) begin
                            state     <= SETUP;
                            busy      <= 1'b1;
                            cs        <= 1'b0;
                            bit_count <= '0;
                        end else begin
                            busy <= 1'b0;
                            cs   <= 1'b1;
                        end
                    end

                    SETUP: begin
                        if (timer == SETUP_LAST) begin
                            // First rising edge of the frame.
                            state        <= HIGH;
                            timer        <= 8'd0;
                            sclk         <= 1'b1;
                            sclk_posedge <= 1'b1;
                            bit_count    <= bit_count + CW'(1);
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end

                    HIGH: begin
                        if (timer == HALF_LAST) begin
                            // Falling edge: either another bit follows or the frame ends.
                            timer        <= 8'd0;
                            sclk         <= 1'b0;
                            sclk_negedge <= 1'b1;
                            if (bit_count == LAST_BIT) begin
                                state <= HOLD;
                            end else begin
                                state <= LOW;
                            end
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end

                    LOW: begin
                        if (timer == HALF_LAST) begin
                            state        <= HIGH;
                            timer        <= 8'd0;
                            sclk         <= 1'b1;
                            sclk_posedge <= 1'b1;
                            bit_count    <= bit_count + CW'(1);
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end

                    HOLD: begin
                        if (timer == HOLD_LAST) begin
                            // Release cs; a start seen in the done cycle begins the next frame.
                            state <= IDLE;
                            timer <= 8'd0;
                            busy  <= 1'b0;
                            cs    <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            timer <= timer + 8'd1;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        timer <= 8'd0;
                        busy  <= 1'b0;
                        cs    <= 1'b1;
                        sclk  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Self-checking bench for spi_master_sequencer: a default-parameter instance
// (A) and a fast instance (B: DIV=1, FRAME_BITS=8, CS_SETUP=1, CS_HOLD=1).
// Expected frame outcomes are queued when a frame is started; monitors pop and
// compare whenever done or aborted pulses.
module tb_spi_master_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A (defaults)
    logic       rst_a, start_a, abort_a;
    logic       busy_a, done_a, aborted_a, cs_a, sclk_a, sclk_posedge_a, sclk_negedge_a;
    logic [4:0] bit_count_a;

    // Instance B (fast configuration)
    logic       rst_b, start_b, abort_b;
    logic       busy_b, done_b, aborted_b, cs_b, sclk_b, sclk_posedge_b, sclk_negedge_b;
    logic [3:0] bit_count_b;

    spi_master_sequencer u_dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .aborted(aborted_a), .cs(cs_a), .sclk(sclk_a),
        .sclk_posedge(sclk_posedge_a), .sclk_negedge(sclk_negedge_a), .bit_count(bit_count_a)
    );

    spi_master_sequencer #(.DIV(1), .FRAME_BITS(8), .CS_SETUP(1), .CS_HOLD(1)) u_dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .aborted(aborted_b), .cs(cs_b), .sclk(sclk_b),
        .sclk_posedge(sclk_posedge_b), .sclk_negedge(sclk_negedge_b), .bit_count(bit_count_b)
    );

    typedef struct {
        bit is_abort;
        int bits;
        int cs_low;
        int pos;
        int neg;
        int gap;     // cs-high cycles before this frame, -1 = don't care
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- Monitor A ----------------
    int cyc_a = 0, low_a = 0, pos_a = 0, neg_a = 0;
    int high_run_a = 0, gap_a = -1, fall_a = 0, lastpos_a = 0;
    bit prev_cs_a = 1'b1;

    always @(negedge clk) begin
        exp_t e;
        if (rst_a) begin
            low_a = 0; pos_a = 0; neg_a = 0; high_run_a = 0; prev_cs_a = 1'b1;
        end else begin
            cyc_a++;
            if (prev_cs_a && !cs_a) begin
                fall_a = cyc_a;
                gap_a  = high_run_a;
            end
            if (cs_a) high_run_a++; else high_run_a = 0;
            prev_cs_a = cs_a;
            if (!cs_a) low_a++;
            if (sclk_posedge_a) begin
                chk("a_pos_sclk_high", sclk_a, 1);
                if (pos_a == 0) chk("a_first_pos_offset", cyc_a - fall_a, 2);
                else            chk("a_pos_spacing", cyc_a - lastpos_a, 8);
                lastpos_a = cyc_a;
                pos_a++;
            end
            if (sclk_negedge_a) neg_a++;
            if (done_a || aborted_a) begin
                chk("a_done_abort_excl", done_a && aborted_a, 0);
                chk("a_cs_high_at_end", cs_a, 1);
                if (exp_a.size() == 0) begin
                    chk("a_unexpected_end", 1, 0);
                end else begin
                    e = exp_a.pop_front();
                    chk("a_end_kind", aborted_a, e.is_abort);
                    chk("a_bit_count", bit_count_a, e.bits);
                    chk("a_cs_low_len", low_a, e.cs_low);
                    chk("a_posedges", pos_a, e.pos);
                    chk("a_negedges", neg_a, e.neg);
                    if (e.gap >= 0) chk("a_cs_gap", gap_a, e.gap);
                end
                low_a = 0; pos_a = 0; neg_a = 0;
            end
        end
    end

    // ---------------- Monitor B ----------------
    int low_b = 0, pos_b = 0, neg_b = 0, hi_b = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_b) begin
            low_b = 0; pos_b = 0; neg_b = 0; hi_b = 0;
        end else begin
            if (!cs_b) low_b++;
            if (sclk_b) hi_b++;
            if (sclk_posedge_b) pos_b++;
            if (sclk_negedge_b) neg_b++;
            if (done_b || aborted_b) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected_end", 1, 0);
                end else begin
                    e = exp_b.pop_front();
                    chk("b_end_kind", aborted_b, e.is_abort);
                    chk("b_bit_count", bit_count_b, e.bits);
                    chk("b_cs_low_len", low_b, e.cs_low);
                    chk("b_posedges", pos_b, e.pos);
                    chk("b_negedges", neg_b, e.neg);
                    chk("b_sclk_high_cycles", hi_b, e.pos);
                end
                low_b = 0; pos_b = 0; neg_b = 0; hi_b = 0;
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic start_pulse_a();
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
    endtask

    task automatic wait_idle_a(input int maxc);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (busy_a && n < maxc);
        chk("a_idle_timeout", busy_a, 0);
    endtask

    task automatic wait_done_a(input int maxc);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!done_a && n < maxc);
        chk("a_done_timeout", done_a, 1);
    endtask

    task automatic wait_pos_a(input int count, input int maxc);
        int n, c;
        n = 0; c = 0;
        while (c < count && n < maxc) begin
            @(negedge clk); n++;
            if (sclk_posedge_a) c++;
        end
        chk("a_posedge_wait", c, count);
    endtask

    // ---------------- Main sequence ----------------
    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; abort_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_aborted", aborted_a, 0);
        chk("rst_cs", cs_a, 1);
        chk("rst_sclk", sclk_a, 0);
        chk("rst_posedge", sclk_posedge_a, 0);
        chk("rst_negedge", sclk_negedge_a, 0);
        chk("rst_bit_count", bit_count_a, 0);
        chk("rst_b_cs", cs_b, 1);
        chk("rst_b_sclk", sclk_b, 0);
        #1 rst_a = 1'b0; rst_b = 1'b0;

        // Abort while idle does nothing
        @(posedge clk); #1 abort_a = 1'b1;
        @(posedge clk); #1 abort_a = 1'b0;
        @(negedge clk);
        chk("idle_abort_aborted", aborted_a, 0);
        chk("idle_abort_busy", busy_a, 0);
        chk("idle_abort_cs", cs_a, 1);

        // Single frame; a start pulse mid-frame must be ignored
        exp_a.push_back('{1'b0, 16, 128, 16, 16, -1});
        start_pulse_a();
        @(negedge clk);
        chk("start_cs_low", cs_a, 0);
        chk("start_busy", busy_a, 1);
        repeat (40) @(negedge clk);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        wait_idle_a(300);
        chk("final_bit_count", bit_count_a, 16);
        repeat (3) @(negedge clk);
        chk("no_restart_busy", busy_a, 0);
        chk("no_restart_cs", cs_a, 1);
        chk("hold_bit_count", bit_count_a, 16);

        // Start held high: three back-to-back frames, one-cycle cs gap
        exp_a.push_back('{1'b0, 16, 128, 16, 16, -1});
        exp_a.push_back('{1'b0, 16, 128, 16, 16, 1});
        exp_a.push_back('{1'b0, 16, 128, 16, 16, 1});
        @(posedge clk); #1 start_a = 1'b1;
        wait_done_a(300);
        wait_done_a(300);
        @(posedge clk); #1 start_a = 1'b0;
        @(negedge clk);
        chk("b2b_third_busy", busy_a, 1);
        wait_idle_a(300);

        // start and abort together in idle: start wins
        exp_a.push_back('{1'b0, 16, 128, 16, 16, -1});
        @(posedge clk); #1 start_a = 1'b1; abort_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0; abort_a = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", busy_a, 1);
        chk("start_abort_cs", cs_a, 0);
        wait_idle_a(300);

        // Abort after the 5th rising edge
`ifdef SPI_SEQ_ABORT_EN
        exp_a.push_back('{1'b1, 5, 35, 5, 4, -1});
`else
        exp_a.push_back('{1'b0, 16, 128, 16, 16, -1});
`endif
        start_pulse_a();
        wait_pos_a(5, 200);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
`ifdef SPI_SEQ_ABORT_EN
        chk("abort_cs", cs_a, 1);
        chk("abort_sclk", sclk_a, 0);
        chk("abort_aborted", aborted_a, 1);
        chk("abort_done", done_a, 0);
        chk("abort_negedge", sclk_negedge_a, 0);
        chk("abort_busy", busy_a, 0);
`else
        chk("noabort_cs", cs_a, 0);
        chk("noabort_sclk", sclk_a, 1);
        chk("noabort_aborted", aborted_a, 0);
`endif
        chk("abort_bit_count", bit_count_a, 5);
        wait_idle_a(300);

        // Asynchronous reset in the middle of a HIGH phase
        start_pulse_a();
        wait_pos_a(3, 200);
        #2 rst_a = 1'b1;
        #1;
        chk("async_rst_cs", cs_a, 1);
        chk("async_rst_sclk", sclk_a, 0);
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_bit_count", bit_count_a, 0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_a = 1'b0;
        exp_a.push_back('{1'b0, 16, 128, 16, 16, -1});
        start_pulse_a();
        @(negedge clk);
        chk("post_rst_cs", cs_a, 0);
        wait_idle_a(300);

        // Fast configuration frame
        exp_b.push_back('{1'b0, 8, 17, 8, 8, -1});
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        @(negedge clk);
        chk("b_start_cs", cs_b, 0);
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (busy_b && n < 100);
            chk("b_idle_timeout", busy_b, 0);
        end
        chk("b_final_bit_count", bit_count_b, 8);

        // Every queued expectation must have been consumed
        repeat (5) @(negedge clk);
        chk("sb_a_empty", exp_a.size(), 0);
        chk("sb_b_empty", exp_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
